// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: state encoding,
// matrix dimensions, key-code mapping and row priority pick.
package keypad_pkg;

  localparam int COL_W = 4;
  localparam int ROW_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Hex code of a key is row*4+col.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic [1:0] low_row(input logic [ROW_W-1:0] rows_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = ROW_W - 1; i >= 0; i--)
      if (!rows_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-tick counter shared by press confirmation and release confirmation;
// hit_o fires on the tick that makes THRESH consecutive matching samples.
module keypad_debounce #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic lvl_i,
  input  logic want_i,
  output logic hit_o
);

  localparam int CW = $clog2(THRESH + 1);

  logic [CW-1:0] cnt_q;
  logic          stable;

  assign stable = tick_i & en_i & (lvl_i == want_i);
  assign hit_o  = stable && (cnt_q == CW'(THRESH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (stable) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a 4-digit code
// history. Define KEYPAD_DEBOUNCE_EN for multi-tick debounce; otherwise one tick.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROW_W-1:0] row_n,
  output logic [COL_W-1:0] col_n,
  input  logic             clear,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             key_down,
  output logic [15:0]      hex_out
);

`ifdef KEYPAD_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int THRESH = DEB_EN ? DEBOUNCE_SCANS : 1;
  localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [ROW_W-1:0] sync1_q, sync2_q;
  logic [DW-1:0]    div_q;
  logic             tick;
  state_e           state_q;
  logic [1:0]       col_q, row_q;
  logic [3:0]       code_q;
  logic             valid_q, down_q;
  logic [15:0]      hex_q;
  logic             row_lvl, hit;
  logic [3:0]       new_code;

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign row_lvl  = sync2_q[row_q];
  assign new_code = key_map(row_q, col_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      div_q   <= '0;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
    end
  end

  // Count is held at zero outside the confirm states, so entry always starts fresh.
  keypad_debounce #(.THRESH(THRESH)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick),
    .clr_i  ((state_q == SCAN) || (state_q == PRESSED)),
    .en_i   ((state_q == DEBOUNCE) || (state_q == RELEASE)),
    .lvl_i  (row_lvl),
    .want_i (state_q == RELEASE),
    .hit_o  (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      hex_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (clear) hex_q <= '0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (&sync2_q) col_q <= col_q + 2'd1;
            else begin
              row_q   <= low_row(sync2_q);
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_lvl) state_q <= SCAN;
            else if (hit) begin
              code_q  <= new_code;
              valid_q <= 1'b1;
              down_q  <= 1'b1;
              hex_q   <= clear ? {12'h000, new_code} : {hex_q[11:0], new_code};
              state_q <= PRESSED;
            end
          end
          PRESSED: begin
            if (row_lvl) begin
              if (DEB_EN) state_q <= RELEASE;
              else begin
                down_q  <= 1'b0;
                state_q <= SCAN;
              end
            end
          end
          RELEASE: begin
            if (!row_lvl) state_q <= PRESSED;
            else if (hit) begin
              down_q  <= 1'b0;
              state_q <= SCAN;
            end
          end
        endcase
      end
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign hex_out   = hex_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: behavioural keypad + per-tick reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int TH = DEBOUNCE_SCANS;
  localparam bit DEB = 1'b1;
`else
  localparam int TH = 1;
  localparam bit DEB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_down;
  logic [15:0] hex_out;
  logic [15:0] key_mask = '0;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int cyc = 0;

  // reference model state (phase: 0 idle, 1 confirming press, 2 held, 3 confirming release)
  int          m_div, m_col, m_row, m_cnt, m_phase;
  logic [3:0]  m_s1, m_s2, m_code;
  logic        m_valid, m_down;
  logic [15:0] m_hex;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .clear     (clear),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .hex_out   (hex_out)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic logic [3:0] pad_rows(int col);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (key_mask[i*4+col]) r[i] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_div = 0; m_col = 0; m_row = 0; m_cnt = 0; m_phase = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_code = 0; m_valid = 0; m_down = 0; m_hex = 0;
  endtask

  task automatic model_edge();
    logic [3:0]  samp;
    logic [15:0] nhex;
    bit          tk;
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = pad_rows(m_col);
    tk = (m_div == SCAN_DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    m_valid = 0;
    nhex = clear ? 16'h0 : m_hex;
    if (tk) begin
      case (m_phase)
        0: if (samp == 4'hF) m_col = (m_col + 1) % 4;
           else begin
             for (int i = 3; i >= 0; i--) if (!samp[i]) m_row = i;
             m_cnt = 0; m_phase = 1;
           end
        1: if (samp[m_row]) m_phase = 0;
           else begin
             m_cnt++;
             if (m_cnt == TH) begin
               m_code = 4'(m_row * 4 + m_col);
               m_valid = 1; m_down = 1; m_phase = 2;
               nhex = {nhex[11:0], m_code};
             end
           end
        2: if (samp[m_row]) begin
             m_cnt = 0;
             if (DEB) m_phase = 3;
             else begin m_down = 0; m_phase = 0; end
           end
        default: if (!samp[m_row]) m_phase = 2;
           else begin
             m_cnt++;
             if (m_cnt == TH) begin m_down = 0; m_phase = 0; end
           end
      endcase
    end
    m_hex = nhex;
  endtask

  // One clock: advance the model, then compare every output against it.
  task automatic step();
    logic [25:0] got, want;
    logic [3:0]  one;
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    cyc++;
    one = 4'b0001;
    want = {~(one << m_col), m_valid, m_down, m_code, m_hex};
    got  = {col_n, key_valid, key_down, key_code, hex_out};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model cyc=%0d got col=%b v=%b d=%b code=%h hex=%h exp col=%b v=%b d=%b code=%h hex=%h",
               cyc, got[25:22], got[21], got[20], got[19:16], got[15:0],
               want[25:22], want[21], want[20], want[19:16], want[15:0]);
    end
    if (key_valid === 1'b1) nvalid++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(int ph, string name);
    int n;
    n = 0;
    while (m_phase != ph && n < 400) begin step(); n++; end
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL %s timeout phase got %0d exp %0d", name, m_phase, ph);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin step(); n++; end while (m_div != 0 && n < 2 * SCAN_DIV);
  endtask

  task automatic press_release(int k, int hold_ticks);
    key_mask = 16'(1) << k;
    wait_phase(2, "press");
    steps(hold_ticks * SCAN_DIV);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL held_down got %b exp 1", key_down); end
    key_mask = '0;
    wait_phase(0, "release");
    steps(2 * SCAN_DIV);
  endtask

  task automatic test_reset();
    reset = 1'b1; key_mask = '0; clear = 1'b0;
    model_reset();
    steps(3);
    checks += 5;
    if (col_n !== 4'b1110)   begin errors++; $display("FAIL reset_col got %b exp 1110", col_n); end
    if (key_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    if (key_down !== 1'b0)   begin errors++; $display("FAIL reset_down got %b exp 0", key_down); end
    if (key_code !== 4'h0)   begin errors++; $display("FAIL reset_code got %h exp 0", key_code); end
    if (hex_out !== 16'h0)   begin errors++; $display("FAIL reset_hex got %h exp 0000", hex_out); end
    reset = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] seq [4];
    int nv0;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    nv0 = nvalid;
    for (int k = 0; k < 8; k++) begin
      steps(SCAN_DIV);
      checks++;
      if (col_n !== seq[k%4]) begin errors++; $display("FAIL idle_col step %0d got %b exp %b", k, col_n, seq[k%4]); end
    end
    checks++;
    if (nvalid != nv0) begin errors++; $display("FAIL idle_valid got %0d exp %0d", nvalid - nv0, 0); end
  endtask

  task automatic test_single_key();
    int nv0;
    nv0 = nvalid;
    press_release(9, 3);
    checks += 4;
    if (nvalid - nv0 != 1)  begin errors++; $display("FAIL single_count got %0d exp 1", nvalid - nv0); end
    if (key_code !== 4'h9)  begin errors++; $display("FAIL single_code got %h exp 9", key_code); end
    if (hex_out !== 16'h0009) begin errors++; $display("FAIL single_hex got %h exp 0009", hex_out); end
    if (key_down !== 1'b0)  begin errors++; $display("FAIL single_up got %b exp 0", key_down); end
  endtask

  task automatic test_sequence();
    for (int k = 1; k <= 5; k++) press_release(k, 1);
    checks++;
    if (hex_out !== 16'h2345) begin errors++; $display("FAIL seq_hex got %h exp 2345", hex_out); end
  endtask

  task automatic test_bounce();
    int nv0;
    logic [3:0] c0;
    nv0 = nvalid;
    wait_tick();
    key_mask = 16'(1) << m_col;
    steps(SCAN_DIV * ((TH > 1) ? TH - 1 : 1));
    key_mask = '0;
    steps(SCAN_DIV * 2);
    c0 = col_n;
    steps(SCAN_DIV);
    checks += 3;
    if (nvalid != nv0)     begin errors++; $display("FAIL bounce_valid got %0d exp 0", nvalid - nv0); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL bounce_down got %b exp 0", key_down); end
    if (col_n === c0)      begin errors++; $display("FAIL bounce_rotate got %b exp not %b", col_n, c0); end
  endtask

  task automatic test_release_glitch();
    int nv0;
    key_mask = 16'(1) << 6;
    wait_phase(2, "glitch_press");
    steps(SCAN_DIV);
    wait_tick();
    nv0 = nvalid;
    key_mask = '0;
    steps(SCAN_DIV);
    key_mask = 16'(1) << 6;
    steps(SCAN_DIV * 4);
`ifdef KEYPAD_DEBOUNCE_EN
    checks += 2;
    if (nvalid != nv0)     begin errors++; $display("FAIL glitch_valid got %0d exp 0", nvalid - nv0); end
    if (key_down !== 1'b1) begin errors++; $display("FAIL glitch_down got %b exp 1", key_down); end
`endif
    key_mask = '0;
    wait_phase(0, "glitch_release");
    steps(SCAN_DIV);
  endtask

  task automatic test_rollover();
    int nv0;
    key_mask = 16'(1) << 2;
    wait_phase(2, "roll_press");
    nv0 = nvalid;
    key_mask = key_mask | (16'(1) << 13);
    steps(SCAN_DIV * 6);
    checks += 2;
    if (nvalid != nv0)    begin errors++; $display("FAIL roll_valid got %0d exp 0", nvalid - nv0); end
    if (key_code !== 4'h2) begin errors++; $display("FAIL roll_code got %h exp 2", key_code); end
    key_mask = '0;
    wait_phase(0, "roll_release");
    steps(SCAN_DIV);
  endtask

  task automatic test_clear();
    int n;
    for (int k = 10; k <= 13; k++) press_release(k, 0);
    checks++;
    if (hex_out !== 16'hABCD) begin errors++; $display("FAIL clr_pre got %h exp ABCD", hex_out); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (hex_out !== 16'h0000) begin errors++; $display("FAIL clr_hex got %h exp 0000", hex_out); end
    press_release(3, 0);
    clear = 1'b1;
    key_mask = 16'(1) << 7;
    n = 0;
    while (key_valid !== 1'b1 && n < 400) begin step(); n++; end
    clear = 1'b0;
    checks++;
    if (hex_out !== 16'h0007) begin errors++; $display("FAIL clr_accept got %h exp 0007", hex_out); end
    key_mask = '0;
    wait_phase(0, "clr_release");
    steps(SCAN_DIV);
  endtask

  task automatic test_reset_pressed();
    int nv0, n;
    key_mask = 16'(1) << 5;
    wait_phase(2, "rst_press");
    steps(3);
    reset = 1'b1;
    model_reset();
    #1;
    checks += 5;
    if (key_down !== 1'b0)  begin errors++; $display("FAIL rstp_down got %b exp 0", key_down); end
    if (col_n !== 4'b1110)  begin errors++; $display("FAIL rstp_col got %b exp 1110", col_n); end
    if (hex_out !== 16'h0)  begin errors++; $display("FAIL rstp_hex got %h exp 0000", hex_out); end
    if (key_code !== 4'h0)  begin errors++; $display("FAIL rstp_code got %h exp 0", key_code); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid got %b exp 0", key_valid); end
    steps(2);
    reset = 1'b0;
    nv0 = nvalid;
    n = 0;
    while (nvalid == nv0 && n < 400) begin step(); n++; end
    checks += 2;
    if (nvalid - nv0 != 1) begin errors++; $display("FAIL rstp_revalid got %0d exp 1", nvalid - nv0); end
    if (n < SCAN_DIV * (2 + TH)) begin errors++; $display("FAIL rstp_latency got %0d exp %0d", n, SCAN_DIV * (2 + TH)); end
    key_mask = '0;
    wait_phase(0, "rstp_release");
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      key_mask = 16'(1) << $urandom_range(15);
      if ($urandom_range(4) == 0) key_mask = key_mask | (16'(1) << $urandom_range(15));
      for (int i = $urandom_range(60, 1); i > 0; i--) begin
        clear = ($urandom_range(19) == 0);
        step();
      end
      clear = 1'b0;
      key_mask = '0;
      steps($urandom_range(40, 1));
    end
    wait_phase(0, "rand_idle");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_single_key();
    test_sequence();
    test_bounce();
    test_release_glitch();
    test_rollover();
    test_clear();
    test_reset_pressed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per column step and per debounce sample tick.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks required to accept a press or release.
REQ-003 SHALL have port clk  input  1  single system clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n  output  4  keypad column drive, active-low, one-hot-low.
REQ-007 SHALL have port clear  input  1  synchronous clear of digit register.
REQ-008 SHALL have port key_code  output  4  hex code of last accepted key, row*4+col.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on accepted press.
REQ-010 SHALL have port key_down  output  1  level, high from acceptance until accepted release.
REQ-011 SHALL have port hex_out  output  16  last four accepted codes, newest in [3:0], drives the 4-digit display driver.

Function
REQ-012 SHALL pass row_n through a 2-flop synchronizer before any use; sampled value is the synchronizer output.
REQ-013 SHALL generate tick when the divider counter equals SCAN_DIV-1, then wrap the counter to 0.
REQ-014 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 SCAN: on tick, if all sampled rows high, SHALL rotate the driven column 0->1->2->3->0; otherwise SHALL latch column and lowest-index low row, clear the stable count, and go to DEBOUNCE without rotating.
REQ-016 DEBOUNCE: column held; on tick, if the latched row is low, SHALL increment the stable count; at DEBOUNCE_SCANS SHALL update key_code, pulse key_valid for exactly one cycle, shift hex_out left by 4 inserting key_code, set key_down, and go to PRESSED.
REQ-017 DEBOUNCE: on tick with latched row high, SHALL return to SCAN with no output change (bounce rejected).
REQ-018 PRESSED: column held; on tick with latched row high, SHALL clear the count and go to RELEASE.
REQ-019 RELEASE: on tick, latched row high increments the count; at DEBOUNCE_SCANS SHALL clear key_down and go to SCAN; latched row low SHALL return to PRESSED without a new key_valid.
REQ-020 Other keys pressed while in PRESSED or RELEASE SHALL be ignored (no rollover).
REQ-021 clear SHALL zero hex_out next cycle; clear coincident with acceptance SHALL result in hex_out = {12'h000, new code}.
REQ-022 Latency from the DEBOUNCE_SCANS-th stable tick to key_valid SHALL be one clk cycle.

Reset
REQ-023 reset SHALL force: state SCAN, column 0 (col_n=4'b1110), divider 0, counts 0, synchronizer flops 4'hF, key_code 0, key_valid 0, key_down 0, hex_out 0.
REQ-024 reset asserted mid-press SHALL drop key_down immediately and produce no key_valid on deassertion while the key stays held until it is re-debounced from SCAN.

Configuration
REQ-025 With KEYPAD_DEBOUNCE_EN defined, SHALL debounce per REQ-016..REQ-019.
REQ-026 Without KEYPAD_DEBOUNCE_EN, SHALL treat DEBOUNCE_SCANS as 1: accept on the first tick after detection if still low; release on first tick with row high.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enumeration, COL_W/ROW_W = 4, and the code-mapping function.
REQ-028 Sub-module keypad_debounce (stable-tick counter with match/threshold compare) SHALL be instantiated once and shared by DEBOUNCE and RELEASE.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, macro defined)
REQ-029 Reset then idle rows 4'hF -> col_n cycles 1110,1101,1011,0111 every 4 clk, key_valid never asserts.
REQ-030 Hold row 2 low while column 1 is driven -> one key_valid, key_code=4'h9, hex_out=16'h0009, key_down high until release is debounced.
REQ-031 Press keys 1,2,3,4,5 in sequence with full releases -> hex_out=16'h2345.
REQ-032 Row 0 low for only 2 ticks then high -> no key_valid, returns to SCAN, rotation resumes.
REQ-033 Release glitch of 1 tick while pressed -> no second key_valid, key_down stays high.
REQ-034 clear pulse with hex_out=16'hABCD -> 16'h0000; reset during PRESSED -> all outputs 0, col_n=1110.
